// File: rtl/servant_irq_trace_pkg.sv
// Shared constants, record layout and FSM state type for the servant irq/power tracer.
// The optional latency field is enabled by defining IRQ_TRACE_LATENCY_EN.
package servant_irq_trace_pkg;

  localparam logic [1:0]  KIND_IRQ      = 2'd0;
  localparam logic [1:0]  KIND_SLEEP    = 2'd1;
  localparam logic [1:0]  KIND_WAKE     = 2'd2;
  localparam logic [31:0] UNRESOLVED_PC = 32'hFFFF_FFFF;

  localparam int KIND_W   = 2;
  localparam int MCAUSE_W = 4;
  localparam int PC_W     = 32;

`ifdef IRQ_TRACE_LATENCY_EN
  localparam int LAT_W = 16;
`else
  localparam int LAT_W = 0;
`endif

  // Record layout, LSB first: [lat], ts, pc, mcause, kind
  localparam int TS_LSB = LAT_W;

  function automatic int pc_lsb(input int ts_w);
    return LAT_W + ts_w;
  endfunction

  function automatic int mcause_lsb(input int ts_w);
    return LAT_W + ts_w + PC_W;
  endfunction

  function automatic int kind_lsb(input int ts_w);
    return LAT_W + ts_w + PC_W + MCAUSE_W;
  endfunction

  function automatic int entry_w(input int ts_w);
    return KIND_W + MCAUSE_W + PC_W + ts_w + LAT_W;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_PC = 2'd1
  } irq_state_e;

endpackage

// File: rtl/servant_irq_trace_fifo.sv
// DEPTH x WIDTH first-word-fall-through FIFO; rdata is registered and holds
// its last value while empty. A push into a full FIFO is accepted only with a pop.
module servant_irq_trace_fifo
  import servant_irq_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 54
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_nxt;
  logic [AW:0]      count;
  logic [AW:0]      remain;
  logic             do_push;
  logic             do_pop;

  assign empty      = (count == '0);
  assign full       = (count == (AW+1)'(DEPTH));
  assign do_pop     = pop & ~empty;
  assign do_push    = push & (~full | do_pop);
  assign rd_ptr_nxt = rd_ptr + AW'(do_pop);
  assign remain     = count - (AW+1)'(do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Head register: new head is either the word being written (FIFO about to be
  // empty) or the already-stored word at the next read pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rdata  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_ptr_nxt;
      count  <= remain + (AW+1)'(do_push);
      if (do_push && remain == '0) rdata <= wdata;
      else if (remain != '0)       rdata <= mem[rd_ptr_nxt];
    end
  end

endmodule

// File: rtl/servant_irq_tracer.sv
// Interrupt/power event tracer: edge detect, irq capture FSM, arbitration, drop accounting.
// Define IRQ_TRACE_LATENCY_EN to append a 16-bit wake-to-irq latency field to each record.
module servant_irq_tracer
  import servant_irq_trace_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int TS_W    = 16,
  parameter int TIMEOUT = 64,
  parameter int DROP_W  = 8,
  localparam int ENTRY_W = entry_w(TS_W)
) (
  input  logic              wb_clk,
  input  logic              wb_rst_n,
  input  logic [31:0]       i_pc_adr,
  input  logic              i_pc_vld,
  input  logic              i_new_irq,
  input  logic [3:0]        i_mcause3_0,
  input  logic              i_sleep_req,
  input  logic              i_wakeup_req,
  input  logic              i_clr,
  output logic [ENTRY_W-1:0] o_data,
  output logic              o_vld,
  input  logic              i_rdy,
  output logic              o_ovf,
  output logic [DROP_W-1:0] o_drops,
  output logic [1:0]        o_state
);

  localparam int TO_W     = $clog2(TIMEOUT + 1);
  localparam int PC_LSB   = pc_lsb(TS_W);
  localparam int MC_LSB   = mcause_lsb(TS_W);
  localparam int KIND_LSB = kind_lsb(TS_W);

  logic [TS_W-1:0] ts;
  logic            sleep_prev, wake_prev;
  logic            sleep_edge, wake_edge;
  logic [31:0]     last_pc;

  irq_state_e      state;
  logic [TO_W-1:0] to_cnt;
  logic [TS_W-1:0] cap_ts;
  logic [3:0]      cap_mcause;
  logic            irq_done;
  logic [31:0]     irq_pc;

  logic            wake_pend, sleep_pend;
  logic [TS_W-1:0] wake_ts, sleep_ts;
  logic [31:0]     wake_pc, sleep_pc;

  logic            wake_cand, sleep_cand;
  logic            sel_irq, sel_wake, sel_sleep, push;
  logic [ENTRY_W-1:0] rec;

  logic            fifo_full, fifo_empty, pop;
  logic [2:0]      n_drop;
  logic [DROP_W:0] drop_sum;

`ifdef IRQ_TRACE_LATENCY_EN
  logic [15:0] lat_cnt, lat_now, cap_lat;

  // Counts cycles since the last wake edge; the edge cycle itself reads as 0.
  assign lat_now = wake_edge ? 16'd0 : lat_cnt;

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) lat_cnt <= '0;
    else           lat_cnt <= (lat_now == 16'hFFFF) ? 16'hFFFF : lat_now + 16'd1;
  end
`endif

  assign sleep_edge = i_sleep_req  & ~sleep_prev;
  assign wake_edge  = i_wakeup_req & ~wake_prev;
  assign irq_done   = (state == ST_WAIT_PC) &
                      (i_pc_vld | (to_cnt == TO_W'(TIMEOUT - 1)));
  assign irq_pc     = i_pc_vld ? i_pc_adr : UNRESOLVED_PC;
  assign o_state    = state;
  assign o_vld      = ~fifo_empty;
  assign pop        = o_vld & i_rdy;

  // One record per cycle: IRQ beats WAKE beats SLEEP; losers wait in their pending slot.
  always_comb begin
    wake_cand  = wake_pend | wake_edge;
    sleep_cand = sleep_pend | sleep_edge;
    sel_irq    = irq_done;
    sel_wake   = ~irq_done & wake_cand;
    sel_sleep  = ~irq_done & ~wake_cand & sleep_cand;
    push       = sel_irq | sel_wake | sel_sleep;
    rec        = '0;
    if (sel_irq) begin
      rec[KIND_LSB +: KIND_W]   = KIND_IRQ;
      rec[MC_LSB +: MCAUSE_W]   = cap_mcause;
      rec[PC_LSB +: PC_W]       = irq_pc;
      rec[TS_LSB +: TS_W]       = cap_ts;
`ifdef IRQ_TRACE_LATENCY_EN
      rec[0 +: LAT_W]           = cap_lat;
`endif
    end else if (sel_wake) begin
      rec[KIND_LSB +: KIND_W]   = KIND_WAKE;
      rec[PC_LSB +: PC_W]       = wake_pend ? wake_pc : last_pc;
      rec[TS_LSB +: TS_W]       = wake_pend ? wake_ts : ts;
    end else if (sel_sleep) begin
      rec[KIND_LSB +: KIND_W]   = KIND_SLEEP;
      rec[PC_LSB +: PC_W]       = sleep_pend ? sleep_pc : last_pc;
      rec[TS_LSB +: TS_W]       = sleep_pend ? sleep_ts : ts;
    end
  end

  always_comb begin
    n_drop   = 3'((i_new_irq & (state == ST_WAIT_PC)))
             + 3'((wake_edge & wake_pend))
             + 3'((sleep_edge & sleep_pend))
             + 3'((push & fifo_full & ~pop));
    drop_sum = {1'b0, (i_clr ? {DROP_W{1'b0}} : o_drops)} + (DROP_W+1)'(n_drop);
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      ts         <= '0;
      sleep_prev <= 1'b0;
      wake_prev  <= 1'b0;
      last_pc    <= '0;
      o_ovf      <= 1'b0;
      o_drops    <= '0;
      wake_pend  <= 1'b0;
      wake_ts    <= '0;
      wake_pc    <= '0;
      sleep_pend <= 1'b0;
      sleep_ts   <= '0;
      sleep_pc   <= '0;
    end else begin
      ts         <= ts + 1'b1;
      sleep_prev <= i_sleep_req;
      wake_prev  <= i_wakeup_req;
      if (i_pc_vld) last_pc <= i_pc_adr;
      o_ovf   <= (o_ovf & ~i_clr) | (n_drop != 3'd0);
      o_drops <= drop_sum[DROP_W] ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];
      if (sel_wake) begin
        wake_pend <= 1'b0;
      end else if (wake_edge && !wake_pend) begin
        wake_pend <= 1'b1;
        wake_ts   <= ts;
        wake_pc   <= last_pc;
      end
      if (sel_sleep) begin
        sleep_pend <= 1'b0;
      end else if (sleep_edge && !sleep_pend) begin
        sleep_pend <= 1'b1;
        sleep_ts   <= ts;
        sleep_pc   <= last_pc;
      end
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state      <= ST_IDLE;
      to_cnt     <= '0;
      cap_ts     <= '0;
      cap_mcause <= '0;
`ifdef IRQ_TRACE_LATENCY_EN
      cap_lat    <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_new_irq) begin
            state      <= ST_WAIT_PC;
            cap_ts     <= ts;
            cap_mcause <= i_mcause3_0;
            to_cnt     <= '0;
`ifdef IRQ_TRACE_LATENCY_EN
            cap_lat    <= lat_now;
`endif
          end
        end
        ST_WAIT_PC: begin
          if (irq_done) state <= ST_IDLE;
          else          to_cnt <= to_cnt + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  servant_irq_trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (wb_clk),
    .rst_n (wb_rst_n),
    .push  (push),
    .wdata (rec),
    .pop   (pop),
    .rdata (o_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_servant_irq_tracer.sv
// Directed bench for servant_irq_tracer (TS_W=8 so timestamp wrap is reachable quickly).
module tb_servant_irq_tracer;

  localparam int DEPTH = 16;
  localparam int TS_W  = 8;
`ifdef IRQ_TRACE_LATENCY_EN
  localparam int EW = 46 + 16;
`else
  localparam int EW = 46;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   pc_adr = '0;
  logic          pc_vld = 1'b0;
  logic          new_irq = 1'b0;
  logic [3:0]    mcause = '0;
  logic          sleep_req = 1'b0;
  logic          wakeup_req = 1'b0;
  logic          clr = 1'b0;
  logic          rdy = 1'b1;
  logic [EW-1:0] data;
  logic          vld;
  logic          ovf;
  logic [7:0]    drops;
  logic [1:0]    state;

  logic [EW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_errors = 0;
  logic [7:0]    tb_ts;
  int            tb_cyc;
  int            wake_cyc = 0;
  logic [EW-1:0] last_rec;

  servant_irq_tracer #(
    .DEPTH(DEPTH), .TS_W(TS_W), .TIMEOUT(64), .DROP_W(8)
  ) dut (
    .wb_clk(clk), .wb_rst_n(rst_n), .i_pc_adr(pc_adr), .i_pc_vld(pc_vld),
    .i_new_irq(new_irq), .i_mcause3_0(mcause), .i_sleep_req(sleep_req),
    .i_wakeup_req(wakeup_req), .i_clr(clr), .o_data(data), .o_vld(vld),
    .i_rdy(rdy), .o_ovf(ovf), .o_drops(drops), .o_state(state)
  );

  // clock/reset block and reference time base
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tb_ts  <= '0;
      tb_cyc <= 0;
    end else begin
      tb_ts  <= tb_ts + 8'd1;
      tb_cyc <= tb_cyc + 1;
    end
  end

  function automatic logic [EW-1:0] mk(input logic [1:0] k, input logic [3:0] mc,
                                       input logic [31:0] pc, input logic [7:0] t);
`ifdef IRQ_TRACE_LATENCY_EN
    logic [15:0] lat;
    lat = 16'd0;
    if (k == 2'd0) lat = ((tb_cyc - wake_cyc) > 65535) ? 16'hFFFF : 16'(tb_cyc - wake_cyc);
    return {k, mc, pc, t, lat};
`else
    return {k, mc, pc, t};
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic goto_ts(input logic [7:0] t);
    int g;
    g = 0;
    while (tb_ts != t && g < 300) begin
      step(1);
      g++;
    end
    check("goto_ts", 64'(tb_ts), 64'(t));
  endtask

  task automatic wait_drain(input string name);
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 200) begin
      step(1);
      g++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  // scoreboard monitor: compare each popped record against the expected queue
  always @(negedge clk) begin
    if (rst_n && vld && rdy) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL mon_unexpected: got %0h expected no record (t=%0t)", data, $time);
      end else begin
        check("mon_data", 64'(data), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    int t0;
    int t1;
    step(3);
    check("rst_vld", 64'(vld), 64'd0);
    check("rst_state", 64'(state), 64'd0);
    rst_n = 1'b1;
    check("rst_data", 64'(data), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_drops", 64'(drops), 64'd0);

    // 1: irq at ts=10, handler fetch at ts=13, record visible at ts=14
    goto_ts(8'd10);
    new_irq = 1'b1; mcause = 4'd7;
    exp_q.push_back(mk(2'd0, 4'd7, 32'h80, 8'd10));
    step(1);
    new_irq = 1'b0; mcause = 4'd0;
    goto_ts(8'd13);
    pc_vld = 1'b1; pc_adr = 32'h80;
    check("t1_vld_early", 64'(vld), 64'd0);
    step(1);
    pc_vld = 1'b0;
    check("t1_vld_lat", 64'(vld), 64'd1);
    step(4);

    // 2: timeout closes record as unresolved; second irq during capture is dropped
    t0 = tb_cyc;
    new_irq = 1'b1; mcause = 4'd3;
    exp_q.push_back(mk(2'd0, 4'd3, 32'hFFFF_FFFF, tb_ts));
    step(1);
    new_irq = 1'b0;
    check("t2_wait", 64'(state), 64'd1);
    step(4);
    new_irq = 1'b1; mcause = 4'd9;
    step(1);
    new_irq = 1'b0; mcause = 4'd0;
    step(70 - (tb_cyc - t0));
    check("t2_idle", 64'(state), 64'd0);
    check("t2_drops", 64'(drops), 64'd1);
    check("t2_ovf", 64'(ovf), 64'd1);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    check("t2_clr_drops", 64'(drops), 64'd0);
    check("t2_clr_ovf", 64'(ovf), 64'd0);
    wait_drain("t2_drain");

    // 3: irq completion, wake and sleep in one cycle -> IRQ, WAKE, SLEEP back to back
    pc_vld = 1'b1; pc_adr = 32'h100;
    step(1);
    pc_vld = 1'b0;
    step(2);
    t1 = tb_cyc;
    new_irq = 1'b1; mcause = 4'd5;
    exp_q.push_back(mk(2'd0, 4'd5, 32'h100, tb_ts));
    step(1);
    new_irq = 1'b0; mcause = 4'd0;
    step(1);
    pc_vld = 1'b1; pc_adr = 32'h100; sleep_req = 1'b1; wakeup_req = 1'b1;
    wake_cyc = tb_cyc;
    exp_q.push_back(mk(2'd2, 4'd0, 32'h100, tb_ts));
    exp_q.push_back(mk(2'd1, 4'd0, 32'h100, tb_ts));
    step(1);
    pc_vld = 1'b0; sleep_req = 1'b0; wakeup_req = 1'b0;
    check("t3_vld_a", 64'(vld), 64'd1);
    step(1);
    check("t3_vld_b", 64'(vld), 64'd1);
    step(1);
    check("t3_vld_c", 64'(vld), 64'd1);
    step(1);
    check("t3_vld_end", 64'(vld), 64'd0);
    check("t3_span", 64'(tb_cyc - t1), 64'd6);
    wait_drain("t3_drain");

    // 4: 20 sleep edges into a stalled FIFO: 16 stored, 4 dropped, drained in order
    rdy = 1'b0;
    step(2);
    for (int i = 0; i < 20; i++) begin
      sleep_req = 1'b1;
      if (i < DEPTH) begin
        last_rec = mk(2'd1, 4'd0, 32'h100, tb_ts);
        exp_q.push_back(last_rec);
      end
      step(1);
      sleep_req = 1'b0;
      step(1);
    end
    check("t4_ovf", 64'(ovf), 64'd1);
    check("t4_drops", 64'(drops), 64'd4);
    check("t4_vld", 64'(vld), 64'd1);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    check("t4_clr_ovf", 64'(ovf), 64'd0);
    check("t4_clr_drops", 64'(drops), 64'd0);
    clr = 1'b1; sleep_req = 1'b1;
    step(1);
    clr = 1'b0; sleep_req = 1'b0;
    check("t4_clrdrop_ovf", 64'(ovf), 64'd1);
    check("t4_clrdrop_drops", 64'(drops), 64'd1);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    rdy = 1'b1;
    wait_drain("t4_drain");
    step(2);
    check("t4_empty_vld", 64'(vld), 64'd0);
    check("t4_hold_data", 64'(data), 64'(last_rec));

    // 5: timestamp wrap with TS_W=8
    goto_ts(8'd255);
    sleep_req = 1'b1;
    exp_q.push_back(mk(2'd1, 4'd0, 32'h100, 8'd255));
    step(1);
    sleep_req = 1'b0;
    step(1);
    wakeup_req = 1'b1;
    wake_cyc = tb_cyc;
    exp_q.push_back(mk(2'd2, 4'd0, 32'h100, 8'd1));
    step(1);
    wakeup_req = 1'b0;
    wait_drain("t5_drain");

`ifdef IRQ_TRACE_LATENCY_EN
    // 6: wake edge, irq 25 cycles later -> lat 25
    step(2);
    wakeup_req = 1'b1;
    wake_cyc = tb_cyc;
    exp_q.push_back(mk(2'd2, 4'd0, 32'h100, tb_ts));
    step(25);
    new_irq = 1'b1; mcause = 4'd2;
    exp_q.push_back(mk(2'd0, 4'd2, 32'h200, tb_ts));
    check("t6_dist", 64'(tb_cyc - wake_cyc), 64'd25);
    step(1);
    new_irq = 1'b0; mcause = 4'd0; wakeup_req = 1'b0;
    pc_vld = 1'b1; pc_adr = 32'h200;
    step(1);
    pc_vld = 1'b0;
    wait_drain("t6_drain");
`endif

    // reset mid-capture with a record still queued: both are discarded
    rdy = 1'b0;
    sleep_req = 1'b1;
    step(1);
    sleep_req = 1'b0;
    new_irq = 1'b1; mcause = 4'd4;
    step(1);
    new_irq = 1'b0; mcause = 4'd0;
    step(2);
    rst_n = 1'b0;
    #1;
    check("rst2_state", 64'(state), 64'd0);
    check("rst2_vld", 64'(vld), 64'd0);
    check("rst2_data", 64'(data), 64'd0);
    step(2);
    rst_n = 1'b1;
    rdy = 1'b1;
    step(80);
    check("rst2_no_record", 64'(vld), 64'd0);
    check("rst2_idle", 64'(state), 64'd0);
    check("final_queue", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
